// File: rtl/pcie_pipe_phy_status_responder.sv
// PHY-side PIPE responder: acknowledges MAC power-state, rate and receiver-detect requests
// with link-wide PhyStatus/RxStatus handshakes, one request at a time with fixed latencies.
module pcie_pipe_phy_status_responder #(
    parameter int              LANES           = 32,
    parameter int              PLL_LOCK_CYCLES = 16,
    parameter int              PD_LATENCY      = 8,
    parameter int              RATE_LATENCY    = 12,
    parameter int              DETECT_LATENCY  = 20,
    parameter logic [LANES-1:0] RX_PRESENT     = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           pipe_powerdown,
    input  logic [1:0]           pipe_rate,
    input  logic                 pipe_txdetectrxloopback,
    output logic [LANES-1:0]     pipe_phystatus,
    output logic [LANES*3-1:0]   pipe_rxstatus,
    output logic [LANES-1:0]     pipe_rxelecidle,
    output logic [2:0]           cur_powerdown,
    output logic [1:0]           cur_rate,
    output logic                 busy
);

    localparam int MAX_A   = (PD_LATENCY > RATE_LATENCY) ? PD_LATENCY : RATE_LATENCY;
    localparam int MAX_B   = (DETECT_LATENCY > PLL_LOCK_CYCLES) ? DETECT_LATENCY : PLL_LOCK_CYCLES;
    localparam int MAX_LAT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] PLL_END  = CNT_W'(PLL_LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAT_PD   = CNT_W'(PD_LATENCY);
    localparam logic [CNT_W-1:0] LAT_RATE = CNT_W'(RATE_LATENCY);
    localparam logic [CNT_W-1:0] LAT_DET  = CNT_W'(DETECT_LATENCY);

    localparam logic [2:0] ST_RST_HOLD    = 3'd0;
    localparam logic [2:0] ST_IDLE        = 3'd1;
    localparam logic [2:0] ST_PD_WAIT     = 3'd2;
    localparam logic [2:0] ST_RATE_WAIT   = 3'd3;
    localparam logic [2:0] ST_DET_WAIT    = 3'd4;
    localparam logic [2:0] ST_DET_RELEASE = 3'd5;

    localparam logic [2:0] PD_P0 = 3'd0;
    localparam logic [2:0] PD_P0S = 3'd1;
    localparam logic [2:0] PD_P1 = 3'd2;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_phy;
    logic             r_det_pulse;
    logic [2:0]       r_cur_pd;
    logic [1:0]       r_cur_rate;
    logic [2:0]       r_tgt_pd;
    logic [1:0]       r_tgt_rate;

    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_pd_req;
    logic             w_rate_req;
    logic             w_det_req;

    // The counter saturates so a stalled state can never alias back to a match.
    assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    assign w_pd_req   = !pipe_powerdown[2] && (pipe_powerdown != r_cur_pd);
    assign w_rate_req = (pipe_rate != 2'd3) && (pipe_rate != r_cur_rate) &&
                        ((r_cur_pd == PD_P0) || (r_cur_pd == PD_P0S));
    assign w_det_req  = pipe_txdetectrxloopback && (r_cur_pd == PD_P1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RST_HOLD;
            r_cnt       <= '0;
            r_phy       <= 1'b1;
            r_det_pulse <= 1'b0;
            r_cur_pd    <= PD_P1;
            r_cur_rate  <= 2'd0;
            r_tgt_pd    <= PD_P1;
            r_tgt_rate  <= 2'd0;
        end else begin
            // NOTE: pulses default low every cycle; non-blocking assignments let later branches override cleanly.
            r_phy       <= 1'b0;
            r_det_pulse <= 1'b0;
            case (r_state)
                ST_RST_HOLD: begin
                    r_cnt <= w_cnt_inc;
                    if (r_cnt == PLL_END) r_state <= ST_IDLE;
                    else                  r_phy   <= 1'b1;
                end
                ST_IDLE: begin
                    if (w_pd_req) begin
                        r_tgt_pd <= pipe_powerdown;
                        r_cnt    <= CNT_W'(1);
                        r_state  <= ST_PD_WAIT;
                    end else if (w_rate_req) begin
                        r_tgt_rate <= pipe_rate;
                        r_cnt      <= CNT_W'(1);
                        r_state    <= ST_RATE_WAIT;
                    end else if (w_det_req) begin
                        r_cnt   <= CNT_W'(1);
                        r_state <= ST_DET_WAIT;
                    end
                end
                ST_PD_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (r_cnt == LAT_PD) begin
                        r_phy    <= 1'b1;
                        r_cur_pd <= r_tgt_pd;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_RATE_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (r_cnt == LAT_RATE) begin
                        r_phy      <= 1'b1;
                        r_cur_rate <= r_tgt_rate;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_DET_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (r_cnt == LAT_DET) begin
                        r_phy       <= 1'b1;
                        r_det_pulse <= 1'b1;
                        r_state     <= ST_DET_RELEASE;
                    end
                end
                ST_DET_RELEASE: begin
                    if (!pipe_txdetectrxloopback) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves the output unassigned (no latch).
        pipe_rxstatus = '0;
        for (int n = 0; n < LANES; n++) begin
            if (r_det_pulse && RX_PRESENT[n]) pipe_rxstatus[3*n +: 3] = 3'b011;
        end
    end

    assign pipe_phystatus  = {LANES{r_phy}};
    assign pipe_rxelecidle = {LANES{r_cur_pd != PD_P0}};
    assign cur_powerdown   = r_cur_pd;
    assign cur_rate        = r_cur_rate;
    assign busy            = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pcie_pipe_phy_status_responder.sv
// Bench for pcie_pipe_phy_status_responder: directed vector table, hand-written corner
// sequences, then random stimulus against a timestamp-based reference model.
module tb_pcie_pipe_phy_status_responder;

    localparam int LANES    = 32;
    localparam int PLL      = 16;
    localparam int PD_LAT   = 8;
    localparam int RATE_LAT = 12;
    localparam int DET_LAT  = 20;
    localparam logic [LANES-1:0] RXP = 32'h0000_FFFF;
    localparam longint NEVER = 64'sd1 << 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] pd = 3'd2;
    logic [1:0] rate = 2'd0;
    logic det = 1'b0;

    logic [LANES-1:0]   o_phy;
    logic [LANES*3-1:0] o_rx;
    logic [LANES-1:0]   o_eidle;
    logic [2:0]         o_cpd;
    logic [1:0]         o_crate;
    logic               o_busy;

    pcie_pipe_phy_status_responder #(
        .LANES(LANES), .PLL_LOCK_CYCLES(PLL), .PD_LATENCY(PD_LAT),
        .RATE_LATENCY(RATE_LAT), .DETECT_LATENCY(DET_LAT), .RX_PRESENT(RXP)
    ) dut (
        .clk(clk), .rst(rst),
        .pipe_powerdown(pd), .pipe_rate(rate), .pipe_txdetectrxloopback(det),
        .pipe_phystatus(o_phy), .pipe_rxstatus(o_rx), .pipe_rxelecidle(o_eidle),
        .cur_powerdown(o_cpd), .cur_rate(o_crate), .busy(o_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic phy, input logic bsy,
                              input logic [2:0] cpd, input logic [1:0] crate,
                              input logic [95:0] rx);
        check({tag, ".phystatus"}, 96'(o_phy), 96'({LANES{phy}}));
        check({tag, ".busy"}, 96'(o_busy), 96'(bsy));
        check({tag, ".cur_powerdown"}, 96'(o_cpd), 96'(cpd));
        check({tag, ".cur_rate"}, 96'(o_crate), 96'(crate));
        check({tag, ".rxelecidle"}, 96'(o_eidle), 96'({LANES{cpd != 3'd0}}));
        check({tag, ".rxstatus"}, 96'(o_rx), rx);
    endtask

    // One clock: inputs were set at the falling edge, outputs are read at the next one.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; pd = 3'd2; rate = 2'd0; det = 1'b0;
        run(2);
        rst = 1'b0;
        run(PLL);
        check_outs("reset_done", 1'b0, 1'b0, 3'd2, 2'd0, '0);
    endtask

    // Reference model: each accepted request is a timestamped event. m_ack is the edge that
    // acknowledges it, m_eval the first edge at which a new request may be taken.
    longint m_t = 0, m_ack = -1, m_eval = NEVER, m_rst_last = -1000;
    int m_kind = 0;
    bit m_det_hold = 0;
    logic [2:0] m_pd = 3'd2, m_tgt_pd = 3'd2;
    logic [1:0] m_rate = 2'd0, m_tgt_rate = 2'd0;
    logic e_phy, e_busy;
    logic [95:0] e_rx;

    always @(posedge clk) begin
        m_t  = m_t + 1;
        e_rx = '0;
        if (rst) begin
            m_pd = 3'd2; m_rate = 2'd0; m_ack = -1; m_det_hold = 0;
            m_rst_last = m_t; m_eval = m_t + PLL + 1;
        end else if (m_t == m_ack) begin
            if (m_kind == 0) m_pd = m_tgt_pd;
            else if (m_kind == 1) m_rate = m_tgt_rate;
            else begin
                m_det_hold = 1;
                for (int n = 0; n < LANES; n++) e_rx[3*n +: 3] = RXP[n] ? 3'b011 : 3'b000;
            end
        end else if (m_det_hold) begin
            if (!det) begin m_det_hold = 0; m_eval = m_t + 1; end
        end else if (m_t >= m_eval) begin
            if (pd < 3'd4 && pd != m_pd) begin
                m_kind = 0; m_tgt_pd = pd; m_ack = m_t + PD_LAT; m_eval = m_ack + 1;
            end else if (rate != 2'd3 && rate != m_rate && m_pd <= 3'd1) begin
                m_kind = 1; m_tgt_rate = rate; m_ack = m_t + RATE_LAT; m_eval = m_ack + 1;
            end else if (det && m_pd == 3'd2) begin
                m_kind = 2; m_ack = m_t + DET_LAT; m_eval = NEVER;
            end
        end
        e_phy  = (!rst && m_t == m_ack) || (m_t < m_rst_last + PLL);
        e_busy = (m_eval > m_t + 1);
    end

    typedef struct {
        string      name;
        logic       rst;
        logic [2:0] pd;
        logic [1:0] rate;
        logic       det;
        int         cycles;
        logic       phy;
        logic       busy;
        logic [2:0] cpd;
        logic [1:0] crate;
    } vec_t;

    vec_t vecs[$];
    logic [95:0] det_rx;

    initial begin
        vecs.push_back('{"rst_hold",     1'b1, 3'd2, 2'd0, 1'b0,  2, 1'b1, 1'b1, 3'd2, 2'd0});
        vecs.push_back('{"pll_hold",     1'b0, 3'd2, 2'd0, 1'b0, 15, 1'b1, 1'b1, 3'd2, 2'd0});
        vecs.push_back('{"pll_done",     1'b0, 3'd2, 2'd0, 1'b0,  1, 1'b0, 1'b0, 3'd2, 2'd0});
        vecs.push_back('{"pd_code5",     1'b0, 3'd5, 2'd0, 1'b0,  4, 1'b0, 1'b0, 3'd2, 2'd0});
        vecs.push_back('{"p0_wait",      1'b0, 3'd0, 2'd0, 1'b0,  8, 1'b0, 1'b1, 3'd2, 2'd0});
        vecs.push_back('{"p0_ack",       1'b0, 3'd0, 2'd0, 1'b0,  1, 1'b1, 1'b0, 3'd0, 2'd0});
        vecs.push_back('{"p0_settle",    1'b0, 3'd0, 2'd0, 1'b0,  1, 1'b0, 1'b0, 3'd0, 2'd0});
        vecs.push_back('{"rate2_wait",   1'b0, 3'd0, 2'd2, 1'b0, 12, 1'b0, 1'b1, 3'd0, 2'd0});
        vecs.push_back('{"rate2_ack",    1'b0, 3'd0, 2'd2, 1'b0,  1, 1'b1, 1'b0, 3'd0, 2'd2});
        vecs.push_back('{"to_p2",        1'b0, 3'd3, 2'd2, 1'b0,  9, 1'b1, 1'b0, 3'd3, 2'd2});
        vecs.push_back('{"rate_held_p2", 1'b0, 3'd3, 2'd1, 1'b0, 20, 1'b0, 1'b0, 3'd3, 2'd2});
        vecs.push_back('{"p2_to_p0",     1'b0, 3'd0, 2'd1, 1'b0,  9, 1'b1, 1'b0, 3'd0, 2'd2});
        vecs.push_back('{"rate1_start",  1'b0, 3'd0, 2'd1, 1'b0,  1, 1'b0, 1'b1, 3'd0, 2'd2});
        vecs.push_back('{"rate1_wait",   1'b0, 3'd0, 2'd1, 1'b0, 11, 1'b0, 1'b1, 3'd0, 2'd2});
        vecs.push_back('{"rate1_ack",    1'b0, 3'd0, 2'd1, 1'b0,  1, 1'b1, 1'b0, 3'd0, 2'd1});

        det_rx = '0;
        for (int n = 0; n < LANES; n++) det_rx[3*n +: 3] = RXP[n] ? 3'b011 : 3'b000;

        @(negedge clk);
        foreach (vecs[i]) begin
            rst = vecs[i].rst; pd = vecs[i].pd; rate = vecs[i].rate; det = vecs[i].det;
            run(vecs[i].cycles);
            check_outs(vecs[i].name, vecs[i].phy, vecs[i].busy, vecs[i].cpd, vecs[i].crate, '0);
        end

        // Receiver detect in P1: one-cycle RxStatus, busy held until detect drops.
        do_reset();
        det = 1'b1;
        run(DET_LAT);
        check_outs("det_wait", 1'b0, 1'b1, 3'd2, 2'd0, '0);
        run(1);
        check_outs("det_ack", 1'b1, 1'b1, 3'd2, 2'd0, det_rx);
        run(3);
        check_outs("det_hold", 1'b0, 1'b1, 3'd2, 2'd0, '0);
        det = 1'b0;
        run(1);
        check_outs("det_release", 1'b0, 1'b0, 3'd2, 2'd0, '0);

        // Powerdown and rate together: powerdown first, rate re-evaluated the cycle after.
        do_reset();
        pd = 3'd0; rate = 2'd1;
        run(PD_LAT + 1);
        check_outs("simul_pd_ack", 1'b1, 1'b0, 3'd0, 2'd0, '0);
        run(1);
        check_outs("simul_rate_start", 1'b0, 1'b1, 3'd0, 2'd0, '0);
        run(RATE_LAT - 1);
        check_outs("simul_rate_wait", 1'b0, 1'b1, 3'd0, 2'd0, '0);
        run(1);
        check_outs("simul_rate_ack", 1'b1, 1'b0, 3'd0, 2'd1, '0);

        // Reset three cycles into a powerdown change discards it.
        do_reset();
        pd = 3'd0;
        run(3);
        rst = 1'b1; pd = 3'd2;
        run(1);
        check_outs("midrst", 1'b1, 1'b1, 3'd2, 2'd0, '0);
        rst = 1'b0;
        run(PLL);
        check_outs("midrst_recover", 1'b0, 1'b0, 3'd2, 2'd0, '0);

        // Random traffic checked every cycle against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 7) == 0)
                pd = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            if ($urandom_range(0, 9) == 0) rate = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) det = ~det;
            run(1);
            check_outs("rand", e_phy, e_busy, m_pd, m_rate, e_rx);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
